// File: rtl/boss_state_tx.sv
// Boss-state link transmitter: snapshots boss position and game state on each frame tick.
// Serialises each snapshot into a 6-byte packet on a byte-wide valid/ready stream.
module boss_state_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [1:0]  game_active,
  input  logic [11:0] boss_x,
  input  logic [11:0] boss_y,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        pkt_sent,
  output logic        overrun,
  output logic [3:0]  seq
);

  localparam int unsigned PKT_BYTES = 6;
  localparam logic [2:0]  LastIdx   = 3'(PKT_BYTES - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  seq_q, seq_d;
  logic [11:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [1:0]  act_ga_q, act_ga_d;
  logic [3:0]  act_seq_q, act_seq_d;
  logic [11:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [1:0]  pend_ga_q, pend_ga_d;
  logic        pend_q, pend_d;

  logic       tick, xfer, last;
  logic [7:0] b1, b2, b3, b4;

  assign tick = frame_tick & enable & ~rst;
  assign xfer = (state_q == StSend) & tx_ready;
  assign last = xfer & (idx_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    act_ga_d  = act_ga_q;
    act_seq_d = act_seq_q;
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    pend_ga_d = pend_ga_q;
    pend_d    = pend_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d   = StSend;
          idx_d     = 3'd0;
          act_x_d   = boss_x;
          act_y_d   = boss_y;
          act_ga_d  = game_active;
          act_seq_d = seq_q;
        end
      end
      StSend: begin
        if (xfer) idx_d = idx_q + 3'd1;
        if (last) begin
          seq_d = seq_q + 4'd1;
          idx_d = 3'd0;
          // Older pending snapshot goes first; a coincident tick becomes the new pending one.
          if (pend_q) begin
            act_x_d   = pend_x_q;
            act_y_d   = pend_y_q;
            act_ga_d  = pend_ga_q;
            act_seq_d = seq_q + 4'd1;
            pend_d    = tick;
            if (tick) begin
              pend_x_d  = boss_x;
              pend_y_d  = boss_y;
              pend_ga_d = game_active;
            end
          end else if (tick) begin
            act_x_d   = boss_x;
            act_y_d   = boss_y;
            act_ga_d  = game_active;
            act_seq_d = seq_q + 4'd1;
          end else begin
            state_d = StIdle;
          end
        end else if (tick) begin
          pend_d    = 1'b1;
          pend_x_d  = boss_x;
          pend_y_d  = boss_y;
          pend_ga_d = game_active;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 3'd0;
      seq_q     <= 4'd0;
      act_x_q   <= 12'd0;
      act_y_q   <= 12'd0;
      act_ga_q  <= 2'd0;
      act_seq_q <= 4'd0;
      pend_x_q  <= 12'd0;
      pend_y_q  <= 12'd0;
      pend_ga_q <= 2'd0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      act_x_q   <= act_x_d;
      act_y_q   <= act_y_d;
      act_ga_q  <= act_ga_d;
      act_seq_q <= act_seq_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
      pend_ga_q <= pend_ga_d;
      pend_q    <= pend_d;
    end
  end

  assign b1 = act_x_q[11:4];
  assign b2 = {act_x_q[3:0], act_y_q[11:8]};
  assign b3 = act_y_q[7:0];
  assign b4 = {act_seq_q, 2'b00, act_ga_q};

  always_comb begin
    tx_data = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        3'd0:    tx_data = HEADER;
        3'd1:    tx_data = b1;
        3'd2:    tx_data = b2;
        3'd3:    tx_data = b3;
        3'd4:    tx_data = b4;
        3'd5:    tx_data = b1 ^ b2 ^ b3 ^ b4;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid = (state_q == StSend);
  assign busy     = (state_q == StSend);
  assign pkt_sent = last & ~rst;
  assign overrun  = tick & pend_q;
  assign seq      = seq_q;

endmodule

// File: tb/tb_boss_state_tx.sv
// Bench for boss_state_tx: directed scenarios plus a randomized run against a packet-level model.
module tb_boss_state_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1, frame_tick = 1'b0, enable = 1'b0, tx_ready = 1'b0;
  logic [1:0]  game_active = 2'd0;
  logic [11:0] boss_x = 12'd0, boss_y = 12'd0;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, pkt_sent, overrun;
  logic [3:0]  seq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  boss_state_tx dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .game_active(game_active),
    .boss_x     (boss_x),
    .boss_y     (boss_y),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .pkt_sent   (pkt_sent),
    .overrun    (overrun),
    .seq        (seq)
  );

  // Reference model: a current packet as a byte array, a read position and one pending snapshot.
  logic [7:0]  m_pkt [6];
  bit          m_act, m_pend;
  int          m_pos;
  logic [3:0]  m_seq;
  logic [11:0] m_px, m_py;
  logic [1:0]  m_pga;

  logic [7:0]  dut_q[$], mdl_q[$];
  int          dut_sent, dut_ovr;

  logic [11:0] cx, cy;
  logic [1:0]  cga;

  logic [7:0]  s_data, e_data;
  logic        s_valid, s_busy, s_sent, s_ovr, e_valid, e_busy, e_sent, e_ovr;
  logic [3:0]  s_seq, e_seq;

  function automatic void build(input logic [11:0] x, input logic [11:0] y,
                                input logic [1:0] ga, input logic [3:0] sq);
    m_pkt[0] = 8'hA5;
    m_pkt[1] = x[11:4];
    m_pkt[2] = {x[3:0], y[11:8]};
    m_pkt[3] = y[7:0];
    m_pkt[4] = {sq, 2'b00, ga};
    m_pkt[5] = m_pkt[1] ^ m_pkt[2] ^ m_pkt[3] ^ m_pkt[4];
  endfunction

  task automatic cycle(input bit r, input bit t, input bit en, input bit rdy);
    bit q;
    @(negedge clk);
    rst = r; frame_tick = t; enable = en; tx_ready = rdy;
    boss_x = cx; boss_y = cy; game_active = cga;
    #3;
    s_data = tx_data; s_valid = tx_valid; s_busy = busy;
    s_sent = pkt_sent; s_ovr = overrun; s_seq = seq;
    if (tx_valid && tx_ready && !r) dut_q.push_back(tx_data);
    if (pkt_sent) dut_sent++;
    if (overrun) dut_ovr++;
    q = t && en && !r;
    e_valid = m_act;
    e_busy  = m_act;
    e_data  = m_act ? m_pkt[m_pos] : 8'h00;
    e_sent  = m_act && rdy && (m_pos == 5) && !r;
    e_ovr   = q && m_pend;
    e_seq   = m_seq;
    if (r) begin
      m_act = 0; m_pend = 0; m_pos = 0; m_seq = 4'd0;
    end else if (m_act) begin
      if (rdy) begin
        mdl_q.push_back(m_pkt[m_pos]);
        m_pos++;
      end
      if (m_pos == 6) begin
        m_pos = 0;
        m_seq = m_seq + 4'd1;
        if (m_pend) begin
          build(m_px, m_py, m_pga, m_seq);
          m_pend = q;
          if (q) begin m_px = cx; m_py = cy; m_pga = cga; end
        end else if (q) begin
          build(cx, cy, cga, m_seq);
        end else begin
          m_act = 0;
        end
      end else if (q) begin
        m_pend = 1; m_px = cx; m_py = cy; m_pga = cga;
      end
    end else if (q) begin
      build(cx, cy, cga, m_seq);
      m_act = 1;
      m_pos = 0;
    end
  endtask

  task automatic clear_logs();
    dut_q.delete(); mdl_q.delete();
    dut_sent = 0; dut_ovr = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 1, 1);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", s_data); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
    checks++; if (s_sent !== 1'b0 || s_ovr !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got sent=%b ovr=%b expected 0 0", s_sent, s_ovr);
    end
    checks++; if (s_seq !== 4'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", s_seq); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [6] = '{8'hA5, 8'h3C, 8'h01, 8'hF4, 8'h01, 8'hC8};
    cx = 12'h3C0; cy = 12'h1F4; cga = 2'd1;
    cycle(0, 1, 1, 1);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_tick_cycle: valid %b expected 0", s_valid); end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 1);
      checks++;
      if (s_valid !== 1'b1 || s_data !== exp_b[i] || s_sent !== (i == 5)) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b d=%h sent=%b expected v=1 d=%h sent=%b",
                 i, s_valid, s_data, s_sent, exp_b[i], (i == 5));
      end
    end
    cycle(0, 0, 1, 1);
    checks++; if (s_busy !== 1'b0 || s_seq !== 4'd1) begin
      errors++; $display("FAIL single_after: got busy=%b seq=%0d expected busy=0 seq=1", s_busy, s_seq);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [6] = '{8'hA5, 8'h3C, 8'h01, 8'hF4, 8'h11, 8'hD8};
    clear_logs();
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      checks++; if (s_valid !== 1'b1 || s_data !== 8'h01) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=01", i, s_valid, s_data);
      end
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1);
    checks++; if (dut_q.size() != 6) begin
      errors++; $display("FAIL bp_count: got %0d bytes expected 6", dut_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (dut_q[i] !== exp_b[i]) begin
          errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, dut_q[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_tick_during_send();
    logic [7:0] exp_b [12] = '{8'hA5, 8'h3C, 8'h01, 8'hF4, 8'h01, 8'hC8,
                               8'hA5, 8'h01, 8'h00, 8'h20, 8'h11, 8'h30};
    cycle(1, 0, 1, 1);
    clear_logs();
    cx = 12'h3C0; cy = 12'h1F4; cga = 2'd1;
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    cx = 12'h010; cy = 12'h020;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1);
    checks++; if (dut_q.size() != 12 || dut_sent != 2 || dut_ovr != 0) begin
      errors++; $display("FAIL tds_counts: got bytes=%0d sent=%0d ovr=%0d expected 12 2 0",
                         dut_q.size(), dut_sent, dut_ovr);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++; if (dut_q[i] !== exp_b[i]) begin
          errors++; $display("FAIL tds_byte%0d: got %h expected %h", i, dut_q[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    clear_logs();
    cx = 12'h123; cy = 12'h456; cga = 2'd2;
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cx = 12'h789; cy = 12'hABC; cga = 2'd3;
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cx = 12'hDEF; cy = 12'h0F0; cga = 2'd1;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 1);
    checks++; if (dut_ovr != 1 || dut_sent != 2 || dut_q.size() != 12) begin
      errors++; $display("FAIL ovr_counts: got ovr=%0d sent=%0d bytes=%0d expected 1 2 12",
                         dut_ovr, dut_sent, dut_q.size());
    end else begin
      b = dut_q[7];
      checks++; if (b !== 8'hDE) begin errors++; $display("FAIL ovr_latest: got %h expected DE", b); end
      for (int i = 0; i < 12; i++) begin
        checks++; if (dut_q[i] !== mdl_q[i]) begin
          errors++; $display("FAIL ovr_byte%0d: got %h expected %h", i, dut_q[i], mdl_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cx = 12'h3C0; cy = 12'h1F4; cga = 2'd1;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 1);
    checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_seq !== 4'd0 || s_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_state: got v=%b b=%b seq=%0d d=%h expected 0 0 0 00",
                         s_valid, s_busy, s_seq, s_data);
    end
    clear_logs();
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    checks++; if (s_valid !== 1'b1 || s_data !== 8'hA5) begin
      errors++; $display("FAIL rstmid_header: got v=%b d=%h expected v=1 d=A5", s_valid, s_data);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);
    checks++; if (dut_q.size() != 6 || dut_q != mdl_q) begin
      errors++; $display("FAIL rstmid_packet: got %0d bytes, differing from the %0d model bytes",
                         dut_q.size(), mdl_q.size());
    end
  endtask

  task automatic test_enable_off();
    int vcount = 0;
    logic [3:0] seq0;
    clear_logs();
    cycle(0, 0, 0, 1);
    seq0 = s_seq;
    for (int i = 0; i < 12; i++) begin
      cycle(0, (i % 4 == 1), 0, 1);
      if (s_valid) vcount++;
    end
    checks++; if (vcount != 0 || s_seq !== seq0 || dut_ovr != 0) begin
      errors++; $display("FAIL en_off_idle: got valid_cycles=%0d seq=%0d ovr=%0d expected 0 %0d 0",
                         vcount, s_seq, dut_ovr, seq0);
    end
    cx = 12'h5A5; cy = 12'hA5A; cga = 2'd2;
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cx = 12'h0FF; cy = 12'hF00; cga = 2'd3;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 14; i++) cycle(0, (i % 2 == 0), 0, 1);
    checks++; if (dut_sent != 2 || dut_ovr != 0 || dut_q.size() != 12 || dut_q != mdl_q) begin
      errors++; $display("FAIL en_off_drain: got sent=%0d ovr=%0d bytes=%0d expected 2 0 12 matching model",
                         dut_sent, dut_ovr, dut_q.size());
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] b15, b16;
    cycle(1, 0, 1, 1);
    clear_logs();
    for (int p = 0; p < 17; p++) begin
      cx = 12'($urandom); cy = 12'($urandom); cga = 2'($urandom);
      cycle(0, 1, 1, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);
    end
    cycle(0, 0, 1, 1);
    checks++; if (dut_q.size() != 102) begin
      errors++; $display("FAIL wrap_count: got %0d bytes expected 102", dut_q.size());
    end else begin
      b15 = dut_q[94];
      b16 = dut_q[100];
      checks++; if (b15[7:4] !== 4'hF || b16[7:4] !== 4'h0) begin
        errors++; $display("FAIL wrap_b4: got pkt16 seq=%h pkt17 seq=%h expected F 0", b15[7:4], b16[7:4]);
      end
    end
    checks++; if (s_seq !== 4'd1) begin errors++; $display("FAIL wrap_seq: got %0d expected 1", s_seq); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cx = 12'($urandom); cy = 12'($urandom); cga = 2'($urandom);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
      checks++;
      if (s_valid !== e_valid || s_data !== e_data || s_busy !== e_busy) begin
        errors++; $display("FAIL rand_stream cyc%0d: got v=%b d=%h b=%b expected v=%b d=%h b=%b",
                           i, s_valid, s_data, s_busy, e_valid, e_data, e_busy);
      end
      checks++;
      if (s_sent !== e_sent || s_ovr !== e_ovr || s_seq !== e_seq) begin
        errors++; $display("FAIL rand_status cyc%0d: got sent=%b ovr=%b seq=%0d expected %b %b %0d",
                           i, s_sent, s_ovr, s_seq, e_sent, e_ovr, e_seq);
      end
    end
  endtask

  initial begin
    m_act = 0; m_pend = 0; m_pos = 0; m_seq = 4'd0;
    m_px = 12'd0; m_py = 12'd0; m_pga = 2'd0;
    cx = 12'd0; cy = 12'd0; cga = 2'd0;
    clear_logs();
    test_reset();
    test_single();
    test_backpressure();
    test_tick_during_send();
    test_overrun();
    test_reset_mid();
    test_enable_off();
    test_seq_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
